// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reconfiguration controller: FSM states, write phases,
// default dynamic-config addresses and the write-list entry format.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_WRITE,
    ST_LOAD,
    ST_ERROR
  } ctrl_state_t;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_SETUP,
    WR_CLK,
    WR_HOLD,
    WR_GAP
  } wr_phase_t;

  localparam logic [5:0] DEF_ADDR_C0_DIV = 6'h00;
  localparam logic [5:0] DEF_ADDR_C0_PH  = 6'h01;
  localparam logic [5:0] DEF_ADDR_C1_DIV = 6'h02;
  localparam logic [5:0] DEF_ADDR_C1_PH  = 6'h03;

  localparam int NUM_WRITES = 4;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_entry_t;

  function automatic wr_entry_t make_entry(input logic [5:0] addr, input logic [7:0] data);
    wr_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/pll_cfg_writer.sv
// Single-write sequencer for the PLL dynamic-config port: SETUP, CLK, HOLD, GAP.
// A new start during GAP chains the next write with no idle cycle in between.
module pll_cfg_writer
  import pll_ctrl_pkg::*;
(
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] addr,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       dcs,
  output logic       dwe,
  output logic       dclk,
  output logic [5:0] daddr,
  output logic [7:0] di
);

  wr_phase_t phase;
  wr_phase_t phase_nxt;

  assign ready = (phase == WR_IDLE) || (phase == WR_GAP);
  assign done  = (phase == WR_GAP);

  always_comb begin
    phase_nxt = phase;
    unique case (phase)
      WR_IDLE:  if (start) phase_nxt = WR_SETUP;
      WR_SETUP: phase_nxt = WR_CLK;
      WR_CLK:   phase_nxt = WR_HOLD;
      WR_HOLD:  phase_nxt = WR_GAP;
      WR_GAP:   phase_nxt = start ? WR_SETUP : WR_IDLE;
      default:  phase_nxt = WR_IDLE;
    endcase
  end

  // Port strobes are flops decoded from the next phase so they are glitch-free
  // and drop to zero the instant rst_n is asserted.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= WR_IDLE;
      dcs   <= 1'b0;
      dwe   <= 1'b0;
      dclk  <= 1'b0;
      daddr <= 6'd0;
      di    <= 8'd0;
    end else begin
      phase <= phase_nxt;
      dcs   <= (phase_nxt == WR_SETUP) || (phase_nxt == WR_CLK) || (phase_nxt == WR_HOLD);
      dwe   <= (phase_nxt == WR_SETUP) || (phase_nxt == WR_CLK) || (phase_nxt == WR_HOLD);
      dclk  <= (phase_nxt == WR_CLK);
      if (start && ready) begin
        daddr <= addr;
        di    <= data;
      end
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL power-up/lock sequencer with runtime divider reconfiguration through the
// dynamic-config port. Everything runs on the undivided reference clock.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int         RST_HOLD     = 16,
  parameter int         LOCK_TIMEOUT = 4096,
  parameter int         LOCK_STABLE  = 64,
  parameter int         MAX_RETRY    = 3,
  parameter logic [5:0] ADDR_C0_DIV  = DEF_ADDR_C0_DIV,
  parameter logic [5:0] ADDR_C0_PH   = DEF_ADDR_C0_PH,
  parameter logic [5:0] ADDR_C1_DIV  = DEF_ADDR_C1_DIV,
  parameter logic [5:0] ADDR_C1_PH   = DEF_ADDR_C1_PH
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       dcs,
  output logic       dwe,
  output logic       dclk,
  output logic [5:0] daddr,
  output logic [7:0] di,
  output logic       load_reg,
  input  logic       cfg_req,
  input  logic [7:0] cfg_div0,
  input  logic [7:0] cfg_div1,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       clk_ready,
  output logic       busy,
  output logic       error
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int TMR_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int STB_W  = $clog2(LOCK_STABLE + 1);
  localparam int RTY_W  = $clog2(MAX_RETRY + 1);

  ctrl_state_t       state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [STB_W-1:0]  stable_cnt, stable_nxt;
  logic [RTY_W-1:0]  retry_cnt, retry_nxt, retry_inc;
  logic [2:0]        issue_cnt, issue_nxt;
  logic [7:0]        div0_q, div0_nxt, div1_q, div1_nxt;
  logic              pll_reset_nxt, clk_ready_nxt, error_nxt;
  logic              ack_nxt, err_nxt, load_nxt;
  logic              armed, armed_nxt;
  logic              lock_meta, lock_sync;
  logic              take_req;
  logic              wr_start, wr_ready, wr_done;
  wr_entry_t         cur_entry;

  assign busy      = !((state == ST_LOCKED) || (state == ST_ERROR));
  assign retry_inc = retry_cnt + RTY_W'(1);

  // pll_lock comes straight from the PLL's analog domain.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  always_comb begin
    cur_entry = make_entry(ADDR_C0_DIV, div0_q);
    case (issue_cnt[1:0])
      2'd0:    cur_entry = make_entry(ADDR_C0_DIV, div0_q);
      2'd1:    cur_entry = make_entry(ADDR_C0_PH, div0_q - 8'd1);
      2'd2:    cur_entry = make_entry(ADDR_C1_DIV, div1_q);
      default: cur_entry = make_entry(ADDR_C1_PH, div1_q - 8'd1);
    endcase
  end

  // A held request is only honoured once; it must be seen low before re-arming.
  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_cnt;
    timer_nxt     = timer;
    stable_nxt    = stable_cnt;
    retry_nxt     = retry_cnt;
    issue_nxt     = issue_cnt;
    div0_nxt      = div0_q;
    div1_nxt      = div1_q;
    pll_reset_nxt = pll_reset;
    clk_ready_nxt = clk_ready;
    error_nxt     = error;
    ack_nxt       = 1'b0;
    err_nxt       = 1'b0;
    armed_nxt     = armed || !cfg_req;
    wr_start      = 1'b0;
    take_req      = cfg_req && armed &&
                    (((state == ST_LOCKED) && lock_sync) || (state == ST_ERROR));

    unique case (state)
      ST_RST_HOLD: begin
        pll_reset_nxt = 1'b1;
        if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
          pll_reset_nxt = 1'b0;
          state_nxt     = ST_WAIT_LOCK;
          timer_nxt     = '0;
          stable_nxt    = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        timer_nxt  = timer + TMR_W'(1);
        stable_nxt = lock_sync ? stable_cnt + STB_W'(1) : '0;
        if (lock_sync && (stable_cnt == STB_W'(LOCK_STABLE - 1))) begin
          state_nxt     = ST_LOCKED;
          clk_ready_nxt = 1'b1;
          retry_nxt     = '0;
        end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
          retry_nxt = retry_inc;
          if (retry_inc < RTY_W'(MAX_RETRY)) begin
            state_nxt     = ST_RST_HOLD;
            hold_nxt      = '0;
            pll_reset_nxt = 1'b1;
          end else begin
            state_nxt = ST_ERROR;
            error_nxt = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (!lock_sync) begin
          state_nxt     = ST_RST_HOLD;
          hold_nxt      = '0;
          pll_reset_nxt = 1'b1;
          clk_ready_nxt = 1'b0;
          retry_nxt     = '0;
        end
      end
      ST_WRITE: begin
        wr_start = wr_ready && (issue_cnt < 3'(NUM_WRITES));
        if (wr_start) issue_nxt = issue_cnt + 3'd1;
        if (wr_done && (issue_cnt == 3'(NUM_WRITES))) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_RST_HOLD;
        hold_nxt  = '0;
      end
      ST_ERROR: begin
      end
      default: begin
        state_nxt     = ST_RST_HOLD;
        hold_nxt      = '0;
        pll_reset_nxt = 1'b1;
      end
    endcase

    if (take_req) begin
      ack_nxt   = 1'b1;
      armed_nxt = 1'b0;
      if ((cfg_div0 == 8'd0) || (cfg_div1 == 8'd0)) begin
        err_nxt = 1'b1;
      end else begin
        state_nxt     = ST_WRITE;
        issue_nxt     = '0;
        div0_nxt      = cfg_div0;
        div1_nxt      = cfg_div1;
        clk_ready_nxt = 1'b0;
        error_nxt     = 1'b0;
        pll_reset_nxt = 1'b1;
        retry_nxt     = '0;
      end
    end

    load_nxt = (state_nxt == ST_LOAD);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST_HOLD;
      hold_cnt   <= '0;
      timer      <= '0;
      stable_cnt <= '0;
      retry_cnt  <= '0;
      issue_cnt  <= '0;
      div0_q     <= 8'd0;
      div1_q     <= 8'd0;
      pll_reset  <= 1'b1;
      clk_ready  <= 1'b0;
      error      <= 1'b0;
      cfg_ack    <= 1'b0;
      cfg_err    <= 1'b0;
      load_reg   <= 1'b0;
      armed      <= 1'b1;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      timer      <= timer_nxt;
      stable_cnt <= stable_nxt;
      retry_cnt  <= retry_nxt;
      issue_cnt  <= issue_nxt;
      div0_q     <= div0_nxt;
      div1_q     <= div1_nxt;
      pll_reset  <= pll_reset_nxt;
      clk_ready  <= clk_ready_nxt;
      error      <= error_nxt;
      cfg_ack    <= ack_nxt;
      cfg_err    <= err_nxt;
      load_reg   <= load_nxt;
      armed      <= armed_nxt;
    end
  end

  pll_cfg_writer u_writer (
    .refclk (refclk),
    .rst_n  (rst_n),
    .start  (wr_start),
    .addr   (cur_entry.addr),
    .data   (cur_entry.data),
    .ready  (wr_ready),
    .done   (wr_done),
    .dcs    (dcs),
    .dwe    (dwe),
    .dclk   (dclk),
    .daddr  (daddr),
    .di     (di)
  );

endmodule
